rgb2hsv_iter: RTL and testbench

- Sequential RGB→HSV converter; the inverse of the existing HSV→RGB mixer path.
- Its output format is the mixer's input format: h = {sextant[7:0], fraction[7:0]}, sextant 0..5; s and v are 8-bit.
- Used to read back or convert pixel colour into HSV for the mixer.
- Uses one shared iterative restoring divider (one quotient bit per cycle), with valid/ready handshakes on both sides.

---
 rtl/rgb2hsv_iter.sv | 182 ++++++++++++++++++
 tb/tb_rgb2hsv_iter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2hsv_iter.sv
// RGB to HSV converter that produces the HSV mixer's input format.
// One restoring divider is shared: saturation is computed first, then the hue fraction.
module rgb2hsv_iter #(
  parameter int DIV_BITS = 16  // dividend width and iterations per division; only 16 is supported
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] h,
  output logic [7:0]  s,
  output logic [7:0]  v
);

  localparam int CNT_W = $clog2(DIV_BITS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_BITS - 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, DONE} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0]          r_r, r_g, r_b;
  logic [7:0]          r_max, r_delta, r_num, r_s_calc;
  logic [2:0]          r_sext;
  logic [DIV_BITS-1:0] r_div_q;    // dividend shifts out the top, quotient shifts in the bottom
  logic [8:0]          r_rem;
  logic [7:0]          r_divisor;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_h;
  logic [7:0]          r_s, r_v;
  logic                r_out_valid;

  logic                w_accept, w_load_s, w_step, w_last, w_s_done, w_wb, w_xfer;
  logic [7:0]          w_max, w_min, w_num, w_delta, w_frac;
  logic [2:0]          w_sext;
  logic [DIV_BITS-1:0] w_dividend_s, w_q_nx;
  logic [8:0]          w_rem_sh, w_rem_nx;
  logic                w_ge;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  assign w_last = (r_cnt == LAST_ITER);

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nx = PREP;
      PREP:    w_state_nx = DIV_S;
      DIV_S:   if (w_last) w_state_nx = DIV_H;
      DIV_H:   if (w_last) w_state_nx = DONE;
      DONE:    if (r_out_valid && out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Output and control strobes.
  always_comb begin
    in_ready = 1'b0;
    w_load_s = 1'b0;
    w_step   = 1'b0;
    w_wb     = 1'b0;
    w_xfer   = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      PREP:    w_load_s = 1'b1;
      DIV_S,
      DIV_H:   w_step   = 1'b1;
      DONE: begin
        w_wb   = !r_out_valid;
        w_xfer = r_out_valid && out_ready;
      end
      default: in_ready = 1'b0;
    endcase
    w_accept = in_ready && in_valid;
    w_s_done = (r_state == DIV_S) && w_last;
  end

  // Max/min, sextant and hue numerator; ties resolve r > g > b.
  always_comb begin
    w_max  = r_b;
    w_sext = 3'd4;
    w_num  = r_r - r_g;
    if (r_r >= r_g && r_r >= r_b) begin
      w_max = r_r;
      if (r_g >= r_b) begin w_sext = 3'd0; w_num = r_g - r_b; end
      else            begin w_sext = 3'd5; w_num = r_r - r_b; end
    end else if (r_g >= r_b) begin
      w_max = r_g;
      if (r_r > r_b)  begin w_sext = 3'd1; w_num = r_g - r_r; end
      else            begin w_sext = 3'd2; w_num = r_b - r_r; end
    end else begin
      if (r_g > r_r)  begin w_sext = 3'd3; w_num = r_b - r_g; end
      else            begin w_sext = 3'd4; w_num = r_r - r_g; end
    end
    w_min = r_r;
    if (r_g < w_min) w_min = r_g;
    if (r_b < w_min) w_min = r_b;
  end

  assign w_delta      = w_max - w_min;
  assign w_dividend_s = {w_delta, 8'h00} - {8'h00, w_delta};

  // One restoring step; a set remainder MSB means the shifted value already exceeds any divisor.
  assign w_rem_sh = {r_rem[7:0], r_div_q[DIV_BITS-1]};
  assign w_ge     = r_rem[8] || (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
  assign w_q_nx   = {r_div_q[DIV_BITS-2:0], w_ge};

  // A hue quotient of 256 only occurs when num == delta; it saturates to 0xFF.
  assign w_frac = (r_div_q[15:8] != 8'h00) ? 8'hFF : r_div_q[7:0];

  // Datapath.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_max       <= '0;
      r_delta     <= '0;
      r_num       <= '0;
      r_sext      <= '0;
      r_s_calc    <= '0;
      r_div_q     <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_h         <= '0;
      r_s         <= '0;
      r_v         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) {r_r, r_g, r_b} <= rgb;

      if (w_load_s) begin
        r_max     <= w_max;
        r_delta   <= w_delta;
        r_num     <= w_num;
        r_sext    <= w_sext;
        r_div_q   <= w_dividend_s;
        r_divisor <= w_max;
        r_rem     <= '0;
        r_cnt     <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_s_done) begin
          r_s_calc  <= (r_max == 8'h00) ? 8'h00 : w_q_nx[7:0];
          r_div_q   <= {r_num, 8'h00};
          r_divisor <= r_delta;
          r_rem     <= '0;
        end else begin
          r_div_q <= w_q_nx;
          r_rem   <= w_rem_nx;
        end
      end

      if (w_wb) begin
        r_h         <= (r_delta == 8'h00) ? 16'h0000 : {5'b00000, r_sext, w_frac};
        r_s         <= r_s_calc;
        r_v         <= r_max;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign h         = r_h;
  assign s         = r_s;
  assign v         = r_v;

endmodule

// File: tb/tb_rgb2hsv_iter.sv
// Directed bench for rgb2hsv_iter: latency, hue sextants/ties, zero divisors,
// backpressure with ignored input pulses, and asynchronous reset mid-division.
module tb_rgb2hsv_iter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] rgb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] h;
  logic [7:0]  s;
  logic [7:0]  v;

  int checks   = 0;
  int failures = 0;

  localparam int LATENCY = 34;

  typedef struct {
    logic [23:0] px;
    logic [15:0] eh;
    logic [7:0]  es;
    logic [7:0]  ev;
  } vec_t;

  vec_t vecs [8] = '{
    '{24'hC86432, 16'h0055, 8'hBF, 8'hC8},
    '{24'hFF8000, 16'h0080, 8'hFF, 8'hFF},
    '{24'h00FF00, 16'h0200, 8'hFF, 8'hFF},
    '{24'hFFFF00, 16'h00FF, 8'hFF, 8'hFF},
    '{24'h0000FF, 16'h0400, 8'hFF, 8'hFF},
    '{24'hFF00FF, 16'h0500, 8'hFF, 8'hFF},
    '{24'h808080, 16'h0000, 8'h00, 8'h80},
    '{24'h000000, 16'h0000, 8'h00, 8'h00}
  };

  rgb2hsv_iter #(.DIV_BITS(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rgb       (rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h         (h),
    .s         (s),
    .v         (v)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Offer one pixel; lat = edges from accept to out_valid, -1 on timeout, -2 if not accepted.
  task automatic send_pixel(input logic [23:0] px, output int lat);
    bit not_ready;
    lat = -1;
    @(negedge wb_clk_i);
    in_valid  = 1'b1;
    rgb       = px;
    not_ready = (in_ready !== 1'b1);
    @(posedge wb_clk_i);
    #1;
    in_valid = 1'b0;
    if (not_ready) begin
      lat = -2;
    end else begin
      for (int c = 1; c <= 60; c++) begin
        @(posedge wb_clk_i);
        #1;
        if (out_valid === 1'b1) begin
          lat = c;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    checks++;
    if ({h, s, v} !== 32'h0) begin
      failures++;
      $display("FAIL reset_hsv: got h=%h s=%h v=%h exp 0/0/0", h, s, v);
    end
    wb_rst_i = 1'b0;
  endtask

  task automatic test_primary();
    int lat;
    send_pixel(24'hFF0000, lat);
    checks++;
    if (lat !== LATENCY) begin
      failures++;
      $display("FAIL red_latency: got %0d exp %0d", lat, LATENCY);
    end
    checks++;
    if ({h, s, v} !== {16'h0000, 8'hFF, 8'hFF}) begin
      failures++;
      $display("FAIL red_hsv: got h=%h s=%h v=%h exp 0000/ff/ff", h, s, v);
    end
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL red_after_xfer: out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_vectors();
    int lat;
    foreach (vecs[i]) begin
      send_pixel(vecs[i].px, lat);
      checks++;
      if (lat !== LATENCY) begin
        failures++;
        $display("FAIL vec_latency rgb=%h: got %0d exp %0d", vecs[i].px, lat, LATENCY);
      end
      checks++;
      if (h !== vecs[i].eh) begin
        failures++;
        $display("FAIL vec_h rgb=%h: got %h exp %h", vecs[i].px, h, vecs[i].eh);
      end
      checks++;
      if (s !== vecs[i].es) begin
        failures++;
        $display("FAIL vec_s rgb=%h: got %h exp %h", vecs[i].px, s, vecs[i].es);
      end
      checks++;
      if (v !== vecs[i].ev) begin
        failures++;
        $display("FAIL vec_v rgb=%h: got %h exp %h", vecs[i].px, v, vecs[i].ev);
      end
      @(posedge wb_clk_i);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL vec_xfer rgb=%h: out_valid=%b in_ready=%b exp 0/1", vecs[i].px, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  rose;
    out_ready = 1'b0;
    @(negedge wb_clk_i);
    in_valid = 1'b1;
    rgb      = 24'h00FF00;
    @(posedge wb_clk_i);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge wb_clk_i);
      #1;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      in_valid = (c % 3 == 0);
      rgb      = 24'h0000FF ^ 24'(c);
    end
    checks++;
    if (lat !== LATENCY) begin
      failures++;
      $display("FAIL bp_latency: got %0d exp %0d", lat, LATENCY);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      rgb      = 24'hFF00FF;
      @(posedge wb_clk_i);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {h, s, v} !== {16'h0200, 8'hFF, 8'hFF}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b h=%h s=%h v=%h exp 1/0/0200/ff/ff",
                 c, out_valid, in_ready, h, s, v);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    rose = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge wb_clk_i);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_transfer: extra activity seen=%b exp 0", rose);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge wb_clk_i);
    in_valid = 1'b1;
    rgb      = 24'hFF8000;
    @(posedge wb_clk_i);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge wb_clk_i);
    #3;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_busy: in_ready=%b exp 0", in_ready);
    end
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {h, s, v} !== 32'h0) begin
      failures++;
      $display("FAIL arst_immediate: out_valid=%b in_ready=%b h=%h s=%h v=%h exp 0/1/0/0/0",
               out_valid, in_ready, h, s, v);
    end
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    send_pixel(24'hC86432, lat);
    checks++;
    if (lat !== LATENCY) begin
      failures++;
      $display("FAIL arst_latency: got %0d exp %0d", lat, LATENCY);
    end
    checks++;
    if ({h, s, v} !== {16'h0055, 8'hBF, 8'hC8}) begin
      failures++;
      $display("FAIL arst_hsv: got h=%h s=%h v=%h exp 0055/bf/c8", h, s, v);
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    test_reset();
    test_primary();
    test_vectors();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
